// File: rtl/fpadd_pkg.sv
// rtl/fpadd_pkg.sv - shift-mode encodings and constant helpers for the alignment pipe
package fpadd_pkg;

   localparam logic [1:0] MODE_RSA = 2'b00;
   localparam logic [1:0] MODE_RSL = 2'b01;
   localparam logic [1:0] MODE_LSL = 2'b10;

   function automatic int clog2_f(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int min_f(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/fpadd_shift_stage.sv
// rtl/fpadd_shift_stage.sv - one barrel level (shift by 2^LVL) plus its pipeline register
// Sticky tracking exists only when STICKY_EN is defined.
module fpadd_shift_stage
   import fpadd_pkg::*;
#(
   parameter int W    = 27,
   parameter int wE   = 8,
   parameter int TAGW = 8,
   parameter int LVL  = 0
)
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en_i,
   input  logic            valid_i,
   input  logic [W-1:0]    data_i,
`ifdef STICKY_EN
   input  logic            sticky_i,
   output logic            sticky_o,
`endif
   input  logic            kill_i,
   input  logic [1:0]      mode_i,
   input  logic [wE-1:0]   n_i,
   input  logic [TAGW-1:0] tag_i,
   output logic            valid_o,
   output logic [W-1:0]    data_o,
   output logic            kill_o,
   output logic [1:0]      mode_o,
   output logic [wE-1:0]   n_o,
   output logic [TAGW-1:0] tag_o
);

   localparam int SH = 1 << LVL;

   logic            do_shift;
   logic [W-1:0]    data_d;
   logic            valid_q, kill_q;
   logic [W-1:0]    data_q;
   logic [1:0]      mode_q;
   logic [wE-1:0]   n_q;
   logic [TAGW-1:0] tag_q;

   // A killed beat travels unshifted; the top replaces it with the fill pattern.
   always_comb begin
      do_shift = n_i[LVL] && !kill_i;
      data_d   = data_i;
      if (do_shift) begin
         case (mode_i)
            MODE_LSL: data_d = data_i << SH;
            MODE_RSL: data_d = data_i >> SH;
            default:  data_d = $signed(data_i) >>> SH;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         kill_q  <= 1'b0;
         mode_q  <= MODE_RSA;
         n_q     <= '0;
         tag_q   <= '0;
      end else if (en_i) begin
         valid_q <= valid_i;
         data_q  <= data_d;
         kill_q  <= kill_i;
         mode_q  <= mode_i;
         n_q     <= n_i;
         tag_q   <= tag_i;
      end
   end

`ifdef STICKY_EN
   logic lost, sticky_d, sticky_q;

   always_comb begin
      lost = (mode_i == MODE_LSL) ? |data_i[W-1 -: SH] : |data_i[SH-1:0];
      sticky_d = sticky_i | (do_shift & lost);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    sticky_q <= 1'b0;
      else if (en_i) sticky_q <= sticky_d;
   end

   assign sticky_o = sticky_q;
`endif

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign kill_o  = kill_q;
   assign mode_o  = mode_q;
   assign n_o     = n_q;
   assign tag_o   = tag_q;

endmodule

// File: rtl/fpadd_align_pipe.sv
// rtl/fpadd_align_pipe.sv - pipelined barrel shifter aligning an FP-add fraction, one register per level
// Define STICKY_EN to produce the OR of all shifted-out bits on out_sticky.
module fpadd_align_pipe
   import fpadd_pkg::*;
#(
   parameter int wE   = 8,
   parameter int wF   = 23,
   parameter int TAGW = 8
)
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [wF+1:0]   in_frac,
   input  logic [wE-1:0]   in_n,
   input  logic [1:0]      in_mode,
   input  logic [TAGW-1:0] in_tag,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [wF+3:0]   out_frac,
   output logic            out_sticky,
   output logic [TAGW-1:0] out_tag
);

   localparam int W        = wF + 4;
   localparam int maxShift = min_f(clog2_f(W), wE);

   logic            v_s    [0:maxShift];
   logic [W-1:0]    d_s    [0:maxShift];
   logic            kill_s [0:maxShift];
   logic [1:0]      mode_s [0:maxShift];
   logic [wE-1:0]   n_s    [0:maxShift];
   logic [TAGW-1:0] tag_s  [0:maxShift];
`ifdef STICKY_EN
   logic            st_s   [0:maxShift];
   assign st_s[0] = 1'b0;
`endif

   // Every stage, bubbles included, advances only together with the output slot.
   assign in_ready = !out_valid || out_ready;

   assign v_s[0]    = in_valid;
   assign d_s[0]    = {in_frac[wF+1], in_frac, 1'b0};
   assign kill_s[0] = ((in_n >> maxShift) != '0) || (32'(in_n) >= 32'(W));
   assign mode_s[0] = (in_mode == 2'b11) ? MODE_RSA : in_mode;
   assign n_s[0]    = in_n;
   assign tag_s[0]  = in_tag;

   for (genvar i = 0; i < maxShift; i++) begin : g_stage
      fpadd_shift_stage #(
         .W    (W),
         .wE   (wE),
         .TAGW (TAGW),
         .LVL  (i)
      ) u_stage (
         .clk      (clk),
         .rst_n    (rst_n),
         .en_i     (in_ready),
         .valid_i  (v_s[i]),
         .data_i   (d_s[i]),
`ifdef STICKY_EN
         .sticky_i (st_s[i]),
         .sticky_o (st_s[i+1]),
`endif
         .kill_i   (kill_s[i]),
         .mode_i   (mode_s[i]),
         .n_i      (n_s[i]),
         .tag_i    (tag_s[i]),
         .valid_o  (v_s[i+1]),
         .data_o   (d_s[i+1]),
         .kill_o   (kill_s[i+1]),
         .mode_o   (mode_s[i+1]),
         .n_o      (n_s[i+1]),
         .tag_o    (tag_s[i+1])
      );
   end

   assign out_valid = v_s[maxShift];
   assign out_tag   = tag_s[maxShift];

   // Killed beats still carry the original operand, so its sign and OR are at hand here.
   always_comb begin
      out_frac = d_s[maxShift];
      if (kill_s[maxShift]) begin
         out_frac = (mode_s[maxShift] == MODE_RSA) ? {W{d_s[maxShift][W-1]}} : '0;
      end
   end

`ifdef STICKY_EN
   assign out_sticky = kill_s[maxShift] ? |d_s[maxShift] : st_s[maxShift];
`else
   assign out_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_fpadd_align_pipe.sv
// tb/tb_fpadd_align_pipe.sv - directed vectors and scoreboard model for fpadd_align_pipe (STICKY_EN aware)
module tb_fpadd_align_pipe;

   localparam int LAT = 5;
`ifdef STICKY_EN
   localparam bit SE = 1'b1;
`else
   localparam bit SE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [24:0] in_frac = '0;
   logic [7:0]  in_n = '0;
   logic [1:0]  in_mode = '0;
   logic [7:0]  in_tag = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [26:0] out_frac;
   logic        out_sticky;
   logic [7:0]  out_tag;

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   int stalls = 0;

   typedef struct {
      logic [26:0] frac;
      logic        sticky;
      logic [7:0]  tag;
      int          acyc;
      int          astl;
   } exp_t;
   exp_t q[$];

   fpadd_align_pipe #(.wE(8), .wF(23), .TAGW(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_frac    (in_frac),
      .in_n       (in_n),
      .in_mode    (in_mode),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_frac   (out_frac),
      .out_sticky (out_sticky),
      .out_tag    (out_tag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Returns {sticky, frac}: signed/unsigned division or multiplication by 2^n on the operand.
   function automatic logic [27:0] model(input logic [24:0] f, input int n, input logic [1:0] m_in);
      logic [26:0] x, frac;
      logic [1:0]  m;
      logic [63:0] full;
      longint      sx, r;
      logic        st;
      x  = {f[24], f, 1'b0};
      m  = (m_in == 2'd3) ? 2'd0 : m_in;
      sx = x[26] ? (longint'(x) - (longint'(1) << 27)) : longint'(x);
      if (n >= 27) begin
         frac = (m == 2'd0 && x[26]) ? 27'h7FFFFFF : 27'h0;
         st   = (x != 0);
      end else if (m == 2'd0) begin
         r    = sx >>> n;
         frac = r[26:0];
         st   = (longint'(x) % (longint'(1) << n)) != 0;
      end else if (m == 2'd1) begin
         frac = x >> n;
         st   = (longint'(x) % (longint'(1) << n)) != 0;
      end else begin
         full = 64'(x) << n;
         frac = full[26:0];
         st   = (full >> 27) != 0;
      end
      return {st & SE, frac};
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               checks++;
               $display("FAIL spurious_output: got tag %0h, expected no beat", out_tag);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("sb_frac", out_frac, e.frac);
               chk("sb_sticky", out_sticky, e.sticky);
               chk("sb_tag", out_tag, e.tag);
               chk("sb_latency", cyc - e.acyc, LAT + stalls - e.astl);
            end
         end
         if (in_valid && in_ready) begin
            exp_t e;
            logic [27:0] m;
            m = model(in_frac, int'(in_n), in_mode);
            e.frac = m[26:0];
            e.sticky = m[27];
            e.tag = in_tag;
            e.acyc = cyc;
            e.astl = stalls;
            q.push_back(e);
         end
         if (out_valid && !out_ready) stalls++;
      end
   end

   task automatic send(input logic [24:0] f, input int n, input logic [1:0] m, input logic [7:0] t);
      bit done;
      done = 1'b0;
      in_frac = f; in_n = 8'(n); in_mode = m; in_tag = t; in_valid = 1'b1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (in_ready) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         checks++;
         $display("FAIL accept_timeout: got in_ready 0, expected 1 within 60 cycles");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         lat++;
         if (out_valid) break;
      end
   endtask

   task automatic dir(input string name, input logic [24:0] f, input int n, input logic [1:0] m,
                      input logic [26:0] ef, input logic es);
      int lat;
      send(f, n, m, 8'h5A);
      wait_out(lat);
      chk({name, "_frac"}, out_frac, ef);
      chk({name, "_sticky"}, out_sticky, es & SE);
      chk({name, "_lat"}, lat, LAT);
      @(posedge clk); #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (q.size() == 0 && !out_valid) break;
      end
      chk("drained", q.size(), 0);
   endtask

   logic [24:0] sf [8] = '{25'h1234567, 25'h1FFFFFF, 25'h1000001, 25'h0F0F0F0,
                           25'h0000001, 25'h1555555, 25'h0AAAAAA, 25'h1800000};
   int          sn [8] = '{3, 1, 26, 5, 31, 7, 13, 2};
   logic [1:0]  sm [8] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd3, 2'd1, 2'd2};

   initial begin
      chk("model_024", model(25'h1000000, 4, 2'd0), {1'b0, 27'h7E00000});
      chk("model_025a", model(25'h1000000, 4, 2'd1), {1'b0, 27'h0600000});
      chk("model_025b", model(25'h0000001, 1, 2'd2), {1'b0, 27'h0000004});
      chk("model_026", model(25'h0000003, 2, 2'd1), {SE, 27'h0000001});
      chk("model_027a", model(25'h1000000, 40, 2'd0), {SE, 27'h7FFFFFF});
      chk("model_027b", model(25'h1000000, 40, 2'd1), {SE, 27'h0});

      #2 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_frac", out_frac, 0);
      chk("rst_out_sticky", out_sticky, 0);
      chk("rst_out_tag", out_tag, 0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("rel_in_ready", in_ready, 1);
      @(posedge clk); #1;

      dir("r024", 25'h1000000, 4, 2'd0, 27'h7E00000, 1'b0);
      dir("r025a", 25'h1000000, 4, 2'd1, 27'h0600000, 1'b0);
      dir("r025b", 25'h0000001, 1, 2'd2, 27'h0000004, 1'b0);
      dir("r026", 25'h0000003, 2, 2'd1, 27'h0000001, 1'b1);
      dir("r027a", 25'h1000000, 40, 2'd0, 27'h7FFFFFF, 1'b1);
      dir("r027b", 25'h1000000, 40, 2'd1, 27'h0000000, 1'b1);
      dir("n0", 25'h0ABCDEF, 0, 2'd0, 27'h1579BDE, 1'b0);
      dir("n27_kill", 25'h1000001, 27, 2'd0, 27'h7FFFFFF, 1'b1);
      dir("mode11", 25'h1000000, 4, 2'd3, 27'h7E00000, 1'b0);
      dir("lsl_lost", 25'h0C00000, 4, 2'd2, 27'h0000000, 1'b1);

      fork
         begin
            for (int i = 0; i < 8; i++) send(sf[i], sn[i], sm[i], 8'hA0 + 8'(i));
         end
         begin
            for (int k = 0; k < 40; k++) begin
               @(negedge clk);
               if (out_valid) break;
            end
            @(posedge clk); #1;
            out_ready = 1'b0;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               chk("stall_in_ready", in_ready, 0);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain();

      for (int i = 0; i < 7; i++) send(sf[7-i], sn[i], sm[i], 8'hC0 + 8'(i));
      chk("pre_reset_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_frac", out_frac, 0);
      chk("midrst_out_tag", out_tag, 0);
      q.delete();
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("midrel_in_ready", in_ready, 1);
      begin
         int seen;
         seen = 0;
         for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
         end
         chk("dropped_beats", seen, 0);
      end
      @(posedge clk); #1;
      dir("post_rst", 25'h1000000, 4, 2'd1, 27'h0600000, 1'b0);
      drain();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/fpadd_align_pipe.md
FPADD_ALIGN_PIPE -- requirements
Module: fpadd_align_pipe

Interface
REQ-001 SHALL have parameter wE, default 8, exponent-difference width (shift-amount bits).
REQ-002 SHALL have parameter wF, default 23, fraction width.
REQ-003 SHALL have parameter TAGW, default 8, sideband tag width.
REQ-004 SHALL have local constants W = wF+4 and maxShift = min(ceil(log2(W)), wE).
REQ-005 Ports (one clock; reset asynchronous, active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts beat
- in_frac  in  wF+2  two's-complement fraction; MSB is sign
- in_n  in  wE  shift amount, unsigned
- in_mode  in  2  00 right-arith, 01 right-logical, 10 left, 11 reserved (treated as 00)
- in_tag  in  TAGW  sideband, passed through unchanged
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts
- out_frac  out  W  shifted result
- out_sticky  out  1  OR of discarded bits (only with STICKY_EN)
- out_tag  out  TAGW  tag aligned with result

Function
REQ-006 SHALL form x = {in_frac[wF+1], in_frac, 1'b0} (W bits) as the operand.
REQ-007 SHALL compute, by mode: x >>> n (sign fill), x >> n (zero fill), x << n (zero fill).
REQ-008 SHALL implement shifting as maxShift barrel levels; level i shifts by 2^i when n[i]=1.
REQ-009 SHALL assert kill when in_n[wE-1:maxShift] != 0, or when in_n >= W in any mode.
REQ-010 On kill: out_frac SHALL be all copies of x[W-1] for right-arith and zero for the other modes.
REQ-011 SHALL register after every barrel level; latency is exactly maxShift cycles from accept to out_valid.
REQ-012 A beat SHALL be accepted on cycles where in_valid && in_ready are both high.
REQ-013 in_ready SHALL equal !out_valid || out_ready; when low, all stages hold their contents.
REQ-014 SHALL not collapse bubbles; stalls freeze the whole pipe, including invalid slots.
REQ-015 out_frac, out_sticky and out_tag SHALL stay stable while out_valid && !out_ready.
REQ-016 Throughput SHALL be one beat per cycle with out_ready held high.
REQ-017 n = 0 SHALL return x unchanged with sticky 0.

Reset
REQ-018 On rst_n low, all stage valid bits SHALL clear asynchronously: out_valid=0, out_frac=0, out_sticky=0, out_tag=0.
REQ-019 Beats in flight at reset SHALL be dropped; in_ready SHALL be 1 from the first cycle after release.

Configuration
REQ-020 With STICKY_EN defined, out_sticky SHALL be the OR of all bits shifted out (|x on kill), accumulated per level and pipelined with the data.
REQ-021 Without STICKY_EN, out_sticky SHALL be tied to 0 and no sticky registers SHALL exist.

Structure
REQ-022 Package fpadd_pkg SHALL hold the mode encodings (MODE_RSA, MODE_RSL, MODE_LSL) and the min/ceil-log2 constant functions.
REQ-023 Sub-module fpadd_shift_stage SHALL implement one barrel level plus its pipeline register (data, sticky, kill, mode, n remainder, tag, valid), instantiated maxShift times through generate.

Verification (wE=8, wF=23, W=27, maxShift=5)
REQ-024 in_frac=25'h1000000, n=4, mode 00 -> out_frac=27'h7E00000, sticky 0, 5 cycles after accept.
REQ-025 Same operand, mode 01, n=4 -> 27'h0600000; mode 10, in_frac=25'h0000001, n=1 -> 27'h0000004.
REQ-026 in_frac=25'h0000003, mode 01, n=2 -> out_frac=27'h0000001, sticky 1 (STICKY_EN); sticky 0 without it.
REQ-027 in_frac=25'h1000000, n=40, mode 00 -> kill, out_frac=27'h7FFFFFF, sticky 1; mode 01 -> 27'h0.
REQ-028 Stream 8 beats, out_ready low for 3 cycles mid-stream -> in_ready low, no loss or duplication, order and tags preserved; rst_n pulse mid-stream -> out_valid 0 immediately.
